// File: rtl/psum_drain_ctrl_if.sv
// Handshake bundle between the layer scheduler / IFFT front end and the psum drain controller.
// The controller takes the slave view. The scheduler/IFFT side, or a bench, takes the master view.
interface psum_drain_ctrl_if #(
  parameter int ADDRLEN = 12
);
  logic               start;
  logic [ADDRLEN-1:0] base;
  logic [ADDRLEN-1:0] len;
  logic               ready;
  logic               ifftrd;
  logic [ADDRLEN-1:0] rdaddr_ifft;
  logic               rdvalid;
  logic               rdlast;
  logic               busy;
  logic               done;

  modport master (
    output start, base, len, ready,
    input  ifftrd, rdaddr_ifft, rdvalid, rdlast, busy, done
  );

  modport slave (
    input  start, base, len, ready,
    output ifftrd, rdaddr_ifft, rdvalid, rdlast, busy, done
  );
endinterface

// File: rtl/psum_drain_ctrl.sv
// Drains one tile region of the psum buffers into the IFFT stage under a ready handshake.
// It also produces a valid/last strobe delayed to line up with the buffer read latency.
module psum_drain_ctrl #(
  parameter int ADDRLEN = 12,
  parameter int RDLAT   = 2
) (
  input logic              clk,
  input logic              rstn,
  psum_drain_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_FLUSH,
    S_DONE
  } state_t;

  localparam int FW = (RDLAT > 1) ? $clog2(RDLAT) : 1;
  localparam logic [ADDRLEN-1:0] ONE        = ADDRLEN'(1);
  localparam logic [FW-1:0]      FONE       = FW'(1);
  localparam logic [FW-1:0]      FLUSH_LAST = FW'(RDLAT - 1);

  state_t             state_q;
  logic [ADDRLEN-1:0] addr_q;
  logic [ADDRLEN-1:0] len_q;
  logic [ADDRLEN-1:0] cnt_q;
  logic [ADDRLEN-1:0] cnt_d;
  logic [FW-1:0]      flush_q;
  logic               ifftrd_q;
  logic               busy_q;
  logic               done_q;
  logic               issue;
  logic               issue_last;
  logic               vld_q [RDLAT];
  logic               lst_q [RDLAT];

  assign cnt_d      = cnt_q + ONE;
  assign issue      = (state_q == S_ISSUE) && bus.ready;
  assign issue_last = issue && (cnt_d == len_q);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      flush_q  <= '0;
      ifftrd_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            busy_q <= 1'b1;
            len_q  <= bus.len;
            cnt_q  <= '0;
            if (bus.len != '0) begin
              state_q  <= S_ISSUE;
              addr_q   <= bus.base;
              ifftrd_q <= 1'b1;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (bus.ready) begin
            cnt_q <= cnt_d;
            // The address stays on the final word through the flush.
            if (cnt_d == len_q) begin
              state_q <= S_FLUSH;
              flush_q <= '0;
            end else begin
              addr_q <= addr_q + ONE;
            end
          end
        end
        S_FLUSH: begin
          if (flush_q == FLUSH_LAST) begin
            state_q  <= S_DONE;
            ifftrd_q <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            flush_q <= flush_q + FONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // In-flight tracker: stage RDLAT-1 coincides with rddata for the word issued RDLAT cycles ago.
  genvar gi;
  generate
    for (gi = 0; gi < RDLAT; gi++) begin : g_pipe
      if (gi == 0) begin : g_head
        always_ff @(posedge clk or negedge rstn) begin
          if (!rstn) begin
            vld_q[gi] <= 1'b0;
            lst_q[gi] <= 1'b0;
          end else begin
            vld_q[gi] <= issue;
            lst_q[gi] <= issue_last;
          end
        end
      end else begin : g_tail
        always_ff @(posedge clk or negedge rstn) begin
          if (!rstn) begin
            vld_q[gi] <= 1'b0;
            lst_q[gi] <= 1'b0;
          end else begin
            vld_q[gi] <= vld_q[gi-1];
            lst_q[gi] <= lst_q[gi-1];
          end
        end
      end
    end
  endgenerate

  assign bus.ifftrd      = ifftrd_q;
  assign bus.rdaddr_ifft = addr_q;
  assign bus.rdvalid     = vld_q[RDLAT-1];
  assign bus.rdlast      = lst_q[RDLAT-1];
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_psum_drain_ctrl.sv
// Bench for psum_drain_ctrl: scenario tasks drive drains and check the address and done timing.
// A negedge scoreboard matches every rdvalid/rdlast against the issues the bench itself made.
module tb_psum_drain_ctrl;

  localparam int ADDRLEN = 12;
  localparam int RDLAT   = 2;

  typedef struct {
    int                 due;
    bit                 last;
    logic [ADDRLEN-1:0] addr;
  } exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_valid = 0;
  bit   mon_en = 1'b0;
  exp_t exp_q [$];
  bit   pat [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  psum_drain_ctrl_if #(.ADDRLEN(ADDRLEN)) bus ();

  psum_drain_ctrl #(.ADDRLEN(ADDRLEN), .RDLAT(RDLAT)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: each expected word is popped when the DUT shows rdvalid, and it must arrive in its due cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      n_checks++;
      if (bus.rdvalid === 1'b1) begin
        n_valid++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected_valid: cycle %0d rdvalid=1 rdlast=%b, required rdvalid=0", cyc, bus.rdlast);
        end else begin
          e = exp_q.pop_front();
          if (e.due != cyc || bus.rdlast !== e.last) begin
            n_fail++;
            $display("FAIL sb_valid_timing: addr %h got valid at cycle %0d rdlast=%b, required cycle %0d rdlast=%b",
                     e.addr, cyc, bus.rdlast, e.due, e.last);
          end
        end
      end else if (bus.rdlast !== 1'b0 || (exp_q.size() > 0 && exp_q[0].due <= cyc)) begin
        n_fail++;
        $display("FAIL sb_missing_valid: cycle %0d rdvalid=%b rdlast=%b, required a valid for pending word (pending=%0d)",
                 cyc, bus.rdvalid, bus.rdlast, exp_q.size());
        if (exp_q.size() > 0 && exp_q[0].due <= cyc) e = exp_q.pop_front();
      end
    end
  end

  task automatic run_drain(input logic [ADDRLEN-1:0] b, input logic [ADDRLEN-1:0] l,
                           input int mode, input bit poke, input string tag);
    int                 k;
    int                 guard;
    int                 s_cyc;
    int                 exp_lat;
    logic               r;
    logic [ADDRLEN-1:0] ea;
    exp_t               e;
    n_valid   = 0;
    bus.start = 1'b1;
    bus.base  = b;
    bus.len   = l;
    bus.ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    s_cyc = cyc;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.ifftrd !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle_at_start: busy=%b ifftrd=%b, required 0/0", tag, bus.busy, bus.ifftrd);
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.base  = 12'($urandom);
    bus.len   = 12'($urandom);
    k = 0;
    guard = 0;
    while (k < int'(l) && guard < 200) begin
      if (mode == 0) r = 1'b1;
      else if (mode == 1) r = pat[guard % 7];
      else r = 1'($urandom_range(0, 1));
      bus.ready = r;
      if (poke) begin
        if (guard == 1) begin
          bus.start = 1'b1;
          bus.base  = b ^ 12'hA5A;
          bus.len   = l + 12'd3;
        end else begin
          bus.start = 1'b0;
        end
      end
      @(negedge clk);
      ea = b + 12'(k);
      n_checks++;
      if (bus.ifftrd !== 1'b1 || bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.rdaddr_ifft !== ea) begin
        n_fail++;
        $display("FAIL %s_issue: cycle %0d ifftrd=%b busy=%b done=%b addr=%h, required 1/1/0 addr=%h",
                 tag, cyc, bus.ifftrd, bus.busy, bus.done, bus.rdaddr_ifft, ea);
      end
      if (r) begin
        e.due  = cyc + RDLAT;
        e.last = (k == int'(l) - 1);
        e.addr = ea;
        exp_q.push_back(e);
        k++;
      end
      guard++;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    n_checks++;
    if (k < int'(l)) begin
      n_fail++;
      $display("FAIL %s_issue_timeout: issued %0d, required %0d", tag, k, l);
    end
    if (l != '0) begin
      bus.ready = 1'b1;
      for (int j = 0; j < RDLAT; j++) begin
        @(negedge clk);
        n_checks++;
        if (bus.ifftrd !== 1'b1 || bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.rdaddr_ifft !== b + l - 12'd1) begin
          n_fail++;
          $display("FAIL %s_flush: ifftrd=%b done=%b busy=%b addr=%h, required 1/0/1 addr=%h",
                   tag, bus.ifftrd, bus.done, bus.busy, bus.rdaddr_ifft, b + l - 12'd1);
        end
        @(posedge clk); #1;
      end
    end
    bus.ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b1 || bus.ifftrd !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_done_pulse: done=%b ifftrd=%b busy=%b, required 1/0/1", tag, bus.done, bus.ifftrd, bus.busy);
    end
    n_checks++;
    if (exp_q.size() != 0 || n_valid != int'(l)) begin
      n_fail++;
      $display("FAIL %s_valid_count: valids=%0d pending=%0d, required %0d and 0", tag, n_valid, exp_q.size(), l);
    end
    exp_lat = (l == '0) ? 1 : int'(l) + RDLAT + 1;
    if (mode == 0 || l == '0) begin
      n_checks++;
      if (cyc - s_cyc != exp_lat) begin
        n_fail++;
        $display("FAIL %s_latency: start-to-done %0d cycles, required %0d", tag, cyc - s_cyc, exp_lat);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      bus.ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.base  = '0;
    bus.len   = '0;
    bus.ready = 1'b0;
    rstn      = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.ifftrd !== 1'b0 || bus.rdvalid !== 1'b0 || bus.rdlast !== 1'b0 || bus.busy !== 1'b0 ||
        bus.done !== 1'b0 || bus.rdaddr_ifft !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_values: ifftrd=%b rdvalid=%b rdlast=%b busy=%b done=%b addr=%h, required all 0",
               bus.ifftrd, bus.rdvalid, bus.rdlast, bus.busy, bus.done, bus.rdaddr_ifft);
    end
    @(posedge clk); #1;
    rstn   = 1'b1;
    mon_en = 1'b1;
    idle(2);
  endtask

  task automatic test_basic();
    run_drain(12'h010, 12'd8, 0, 1'b0, "basic");
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_after_done: busy=%b done=%b, required 0/0", bus.busy, bus.done);
    end
    @(posedge clk); #1;
    idle(2);
  endtask

  task automatic test_backpressure();
    run_drain(12'h200, 12'd6, 1, 1'b0, "backpressure");
    idle(2);
    run_drain(12'h3A0, 12'd9, 2, 1'b0, "random_ready");
    idle(2);
  endtask

  task automatic test_wrap_and_zero();
    run_drain(12'hFFE, 12'd4, 0, 1'b0, "wrap");
    idle(1);
    run_drain(12'h123, 12'd0, 0, 1'b0, "len_zero");
    idle(2);
  endtask

  task automatic test_start_while_busy();
    run_drain(12'h080, 12'd8, 0, 1'b1, "start_busy");
    idle(2);
  endtask

  task automatic test_async_reset();
    exp_t e;
    bus.start = 1'b1;
    bus.base  = 12'h100;
    bus.len   = 12'd10;
    bus.ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.rdaddr_ifft !== 12'h100 + 12'(i) || bus.ifftrd !== 1'b1) begin
        n_fail++;
        $display("FAIL rst_pre_issue: addr=%h ifftrd=%b, required addr=%h ifftrd=1",
                 bus.rdaddr_ifft, bus.ifftrd, 12'h100 + 12'(i));
      end
      e.due  = cyc + RDLAT;
      e.last = 1'b0;
      e.addr = 12'h100 + 12'(i);
      exp_q.push_back(e);
      @(posedge clk); #1;
    end
    rstn = 1'b0;
    exp_q.delete();
    #1;
    n_checks++;
    if (bus.ifftrd !== 1'b0 || bus.rdvalid !== 1'b0 || bus.rdlast !== 1'b0 || bus.busy !== 1'b0 ||
        bus.done !== 1'b0 || bus.rdaddr_ifft !== 12'h000) begin
      n_fail++;
      $display("FAIL rst_immediate: ifftrd=%b rdvalid=%b rdlast=%b busy=%b done=%b addr=%h, required all 0",
               bus.ifftrd, bus.rdvalid, bus.rdlast, bus.busy, bus.done, bus.rdaddr_ifft);
    end
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_no_done: done=%b busy=%b, required 0/0", bus.done, bus.busy);
      end
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    idle(1);
    run_drain(12'h300, 12'd5, 0, 1'b0, "post_reset");
    idle(2);
  endtask

  task automatic test_back_to_back();
    run_drain(12'h040, 12'd3, 0, 1'b0, "b2b_first");
    run_drain(12'h050, 12'd4, 0, 1'b0, "b2b_second");
    run_drain(12'h7FF, 12'd2, 1, 1'b0, "b2b_third");
    idle(3);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap_and_zero();
    test_start_while_busy();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
